// File: rtl/custom_inputs_pkg.sv
// Shared constants for the custom_inputs Avalon-MM input peripheral.
// Register word offsets and the default debounce period.
package custom_inputs_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_EDGE = 2'd1;
  localparam logic [1:0] REG_MASK = 2'd2;
  localparam logic [1:0] REG_MODE = 2'd3;

  // 1 ms at 50 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/custom_inputs_debounce.sv
// Single-bit input conditioner: 2-flop synchroniser followed by a debouncer.
// stable_next exposes the value stable takes on the coming edge so the parent can capture edges in step.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic stable_next_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter only runs while the synchronised input disagrees with the accepted value.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o      = stable_q;
  assign stable_next_o = stable_d;

endmodule

// File: rtl/custom_inputs.sv
// Avalon-MM slave that debounces push-buttons and DIP switches, latches edges
// into sticky W1C bits and raises a maskable level interrupt.
module custom_inputs
  import custom_inputs_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int NUM_BUTTONS     = 2,
  parameter int NUM_SWITCHES    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    irq,
  input  logic [NUM_BUTTONS-1:0]  buttons_n,
  input  logic [NUM_SWITCHES-1:0] switches
);

  localparam int N = NUM_BUTTONS + NUM_SWITCHES;

  logic [N-1:0]  in_vec;
  logic [N-1:0]  stable_vec;
  logic [N-1:0]  stable_next_vec;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;
  logic [N-1:0]  edges_q;
  logic [N-1:0]  edges_d;
  logic [N-1:0]  mask_q;
  logic [N-1:0]  mask_d;
  logic [N-1:0]  mode_q;
  logic [N-1:0]  mode_d;
  logic          irq_q;
  logic          irq_d;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;
  logic          wr_edge;
  logic          wr_mask;
  logic          wr_mode;

  // Buttons are active-low at the pin; logical 1 always means pressed/on.
  assign in_vec = {switches, ~buttons_n};

  for (genvar i = 0; i < N; i++) begin : g_deb
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk          (clk),
      .reset        (reset),
      .raw_i        (in_vec[i]),
      .stable_o     (stable_vec[i]),
      .stable_next_o(stable_next_vec[i])
    );
  end

  assign rise = ~stable_vec & stable_next_vec;
  assign fall = stable_vec & ~stable_next_vec;

  assign wr_edge = avs_write && (avs_address == REG_EDGE);
  assign wr_mask = avs_write && (avs_address == REG_MASK);
  assign wr_mode = avs_write && (avs_address == REG_MODE);

  // Set terms are applied after the clear so a coincident edge survives the W1C.
  always_comb begin
    edges_d = edges_q;
    if (wr_edge) begin
      edges_d = edges_q & ~avs_writedata[N-1:0];
    end
    edges_d = edges_d | rise | (fall & mode_q);
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_mask) mask_d = avs_writedata[N-1:0];
    if (wr_mode) mode_d = avs_writedata[N-1:0];
  end

  assign irq_d = |(edges_q & mask_q);

  // Read mux uses the current register values, so a same-cycle write is not visible.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      unique case (avs_address)
        REG_DATA: rdata_d = 32'(stable_vec);
        REG_EDGE: rdata_d = 32'(edges_q);
        REG_MASK: rdata_d = 32'(mask_q);
        REG_MODE: rdata_d = 32'(mode_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edges_q <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      edges_q <= edges_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

  if (N < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:N];
  end

endmodule

// File: tb/tb_custom_inputs.sv
// Directed plus randomized bench for custom_inputs with a history-based reference model.
module tb_custom_inputs;
  import custom_inputs_pkg::*;

  localparam int DC = 4;
  localparam int NB = 2;
  localparam int NS = 4;
  localparam int N  = NB + NS;

  logic          clk;
  logic          reset;
  logic [1:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;
  logic [NB-1:0] buttons_n;
  logic [NS-1:0] switches;

  int n_vec;
  int n_bad;

  // Reference state: accepted levels, registers, and a per-edge history of logical pin values
  logic [N-1:0] m_stable;
  logic [N-1:0] m_edge;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_mode;
  logic         m_irq;
  logic [31:0]  m_rdata;
  logic [N-1:0] hist[$];

  custom_inputs #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_BUTTONS    (NB),
    .NUM_SWITCHES   (NS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata (avs_readdata),
    .irq          (irq),
    .buttons_n    (buttons_n),
    .switches     (switches)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stable = '0;
    m_edge   = '0;
    m_mask   = '0;
    m_mode   = '0;
    m_irq    = 1'b0;
    m_rdata  = '0;
    hist.delete();
    for (int k = 0; k < DC + 2; k++) hist.push_back('0);
  endtask

  // An input is accepted once the last DC synchronised samples (pins delayed two edges) all disagree with it.
  task automatic model_step(input logic rd, input logic wr, input logic [1:0] addr,
                            input logic [31:0] wd);
    logic [N-1:0] pin_now;
    logic [N-1:0] nxt;
    logic [N-1:0] e;
    logic         all_diff;
    logic         irq_nxt;
    pin_now = {switches, ~buttons_n};
    if (rd) begin
      case (addr)
        REG_DATA: m_rdata = 32'(m_stable);
        REG_EDGE: m_rdata = 32'(m_edge);
        REG_MASK: m_rdata = 32'(m_mask);
        default:  m_rdata = 32'(m_mode);
      endcase
    end
    irq_nxt = |(m_edge & m_mask);
    nxt = m_stable;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DC + 1; k++) begin
        if (hist[hist.size() - k][i] == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) nxt[i] = ~m_stable[i];
    end
    e = m_edge;
    if (wr && addr == REG_EDGE) e = e & ~wd[N-1:0];
    e = e | (~m_stable & nxt) | (m_stable & ~nxt & m_mode);
    if (wr && addr == REG_MASK) m_mask = wd[N-1:0];
    if (wr && addr == REG_MODE) m_mode = wd[N-1:0];
    m_edge   = e;
    m_stable = nxt;
    m_irq    = irq_nxt;
    hist.push_back(pin_now);
    if (hist.size() > DC + 2) void'(hist.pop_front());
  endtask

  task automatic cycle(input logic rd, input logic wr, input logic [1:0] addr,
                       input logic [31:0] wd);
    avs_read      = rd;
    avs_write     = wr;
    avs_address   = addr;
    avs_writedata = wd;
    @(posedge clk);
    model_step(rd, wr, addr, wd);
    #1;
    check("irq", {31'b0, irq}, {31'b0, m_irq});
    check("readdata", avs_readdata, m_rdata);
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, REG_DATA, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
    #1;
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    int hold;
    n_vec         = 0;
    n_bad         = 0;
    reset         = 1'b1;
    avs_address   = REG_DATA;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    buttons_n     = 2'b11;
    switches      = 4'h0;
    model_reset();
    do_reset();

    // Reset in the middle of a debounce count, then measure acceptance latency
    buttons_n = 2'b10;
    idle(3);
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 1'b0, REG_DATA, 32'h0);
      check("rst_data_latency", avs_readdata, (k == 7) ? 32'h1 : 32'h0);
    end
    cycle(1'b0, 1'b1, REG_EDGE, 32'h3F);
    buttons_n = 2'b11;
    idle(8);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h3F);

    // Glitch of DC-1 cycles is rejected
    buttons_n = 2'b10;
    idle(3);
    buttons_n = 2'b11;
    idle(8);
    cycle(1'b1, 1'b0, REG_DATA, 32'h0);
    check("glitch_data", avs_readdata, 32'h0);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("glitch_edge", avs_readdata, 32'h0);

    // Rising-edge interrupt and W1C
    cycle(1'b0, 1'b1, REG_MASK, 32'h3F);
    buttons_n = 2'b01;
    idle(6);
    check("rise_irq_before", {31'b0, irq}, 32'h0);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("rise_irq", {31'b0, irq}, 32'h1);
    check("rise_edge", avs_readdata, 32'h2);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h2);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    check("w1c_edge", avs_readdata, 32'h0);
    buttons_n = 2'b11;
    idle(8);

    // Both-edge mode versus rise-only
    cycle(1'b0, 1'b1, REG_MODE, 32'h04);
    switches = 4'h1;
    idle(8);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("both_on", avs_readdata, 32'h4);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h04);
    switches = 4'h0;
    idle(8);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("both_off", avs_readdata, 32'h4);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h04);
    cycle(1'b0, 1'b1, REG_MODE, 32'h0);
    switches = 4'h1;
    idle(8);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h3F);
    switches = 4'h0;
    idle(8);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("rise_only_off", avs_readdata, 32'h0);

    // W1C landing on the same edge as a new bit-0 edge
    cycle(1'b0, 1'b1, REG_MODE, 32'h01);
    buttons_n = 2'b10;
    idle(8);
    buttons_n = 2'b11;
    idle(5);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h1);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("collide_edge", avs_readdata, 32'h1);
    check("collide_irq", {31'b0, irq}, 32'h1);
    cycle(1'b0, 1'b1, REG_EDGE, 32'h3F);

    // Masking, read latency, read-during-write
    cycle(1'b0, 1'b1, REG_MODE, 32'h3F);
    cycle(1'b0, 1'b1, REG_MASK, 32'h0);
    buttons_n = 2'b00;
    switches  = 4'hF;
    idle(8);
    check("masked_irq", {31'b0, irq}, 32'h0);
    cycle(1'b1, 1'b0, REG_EDGE, 32'h0);
    check("all_edges", avs_readdata, 32'h3F);
    cycle(1'b0, 1'b1, REG_MASK, 32'h20);
    check("mask_irq_lag", {31'b0, irq}, 32'h0);
    idle(1);
    check("mask_irq", {31'b0, irq}, 32'h1);
    cycle(1'b1, 1'b0, REG_MASK, 32'h0);
    check("mask_readback", avs_readdata, 32'h20);
    cycle(1'b1, 1'b1, REG_MASK, 32'h10);
    check("rdw_old", avs_readdata, 32'h20);
    cycle(1'b1, 1'b0, REG_MASK, 32'h0);
    check("rdw_new", avs_readdata, 32'h10);

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      if (hold == 0) begin
        buttons_n = NB'($urandom);
        switches  = NS'($urandom);
        hold      = $urandom_range(1, 8);
      end
      hold--;
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
